// File: rtl/tof_frame_reader.sv
// ToF distance-frame readout engine: captures per-sensor data-ready edges, arbitrates round-robin,
// burst-reads one frame of zone bytes over a shared single-byte I2C master and streams zone words.
module tof_frame_reader #(
  parameter int          N_SENSORS      = 2,
  parameter int          N_ZONES        = 64,
  parameter int          BYTES_PER_ZONE = 2,
  parameter logic [15:0] DATA_BASE_ADDR = 16'h0400,
  parameter int          TIMEOUT_CYC    = 100000,
  localparam int ZW = 8 * BYTES_PER_ZONE,
  localparam int IW = (N_ZONES > 1) ? $clog2(N_ZONES) : 1,
  localparam int SW = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_rd_enable,
  input  logic [N_SENSORS-1:0] i_tof_int,
  input  logic                 i_i2c_busy,
  input  logic                 i_i2c_done,
  input  logic                 i_i2c_err,
  input  logic [7:0]           i_i2c_rdata,
  output logic                 o_i2c_start,
  output logic [15:0]          o_i2c_addr,
  output logic [SW-1:0]        o_i2c_sensor,
  output logic                 o_zone_valid,
  output logic [SW-1:0]        o_zone_sensor,
  output logic [IW-1:0]        o_zone_idx,
  output logic [ZW-1:0]        o_zone_data,
  output logic                 o_frame_done,
  output logic                 o_frame_err,
  output logic [N_SENSORS-1:0] o_overrun,
  output logic                 o_busy
);

  localparam int NB = N_ZONES * BYTES_PER_ZONE;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t               r_state, w_state_nxt;
  logic [N_SENSORS-1:0] r_int_q, r_pending, r_overrun;
  logic [SW-1:0]        r_rr, r_sensor;
  logic [CW-1:0]        r_byte_cnt;
  logic [IW-1:0]        r_zidx;
  logic [1:0]           r_bsub;
  logic [ZW-1:0]        r_shift;
  logic [TW-1:0]        r_timer;
  logic                 r_start, r_zvalid, r_fdone, r_ferr, r_busy;
  logic [15:0]          r_addr;
  logic [SW-1:0]        r_zsensor;
  logic [IW-1:0]        r_zidx_o;
  logic [ZW-1:0]        r_zdata;

  logic [N_SENSORS-1:0] w_rise, w_clr, w_svc;
  logic [SW:0]          w_pick;
  logic                 w_arb, w_issue, w_rx, w_abort;
  logic                 w_last, w_zend, w_tmo;
  logic [ZW-1:0]        w_shift_nxt;
  logic [SW-1:0]        w_rr_nxt;

  // First pending sensor at or after the round-robin pointer; MSB flags "found".
  function automatic logic [SW:0] f_pick(input logic [N_SENSORS-1:0] pend, input logic [SW-1:0] rr);
    logic [SW:0] res;
    int          j;
    res = '0;
    for (int i = N_SENSORS - 1; i >= 0; i--) begin
      j = int'(rr) + i;
      if (j >= N_SENSORS) j = j - N_SENSORS;
      if (pend[j]) res = {1'b1, SW'(j)};
    end
    return res;
  endfunction

  assign w_pick      = f_pick(r_pending, r_rr);
  assign w_rise      = i_tof_int & ~r_int_q;
  assign w_last      = (r_byte_cnt == CW'(NB - 1));
  assign w_zend      = (r_bsub == 2'(BYTES_PER_ZONE - 1));
  assign w_tmo       = (r_timer == TW'(TIMEOUT_CYC - 1));
  assign w_shift_nxt = ZW'({r_shift, i_i2c_rdata});
  assign w_rr_nxt    = (r_sensor == SW'(N_SENSORS - 1)) ? '0 : r_sensor + 1'b1;

  always_comb begin
    w_clr = '0;
    w_svc = '0;
    for (int s = 0; s < N_SENSORS; s++) begin
      w_clr[s] = w_arb && (w_pick[SW-1:0] == SW'(s));
      w_svc[s] = r_busy && (r_sensor == SW'(s));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_arb       = 1'b0;
    w_issue     = 1'b0;
    w_rx        = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE:  if (i_rd_enable && |r_pending) w_state_nxt = S_ARB;
      S_ARB: begin
        w_arb       = w_pick[SW];
        w_state_nxt = w_pick[SW] ? S_ISSUE : S_IDLE;
      end
      S_ISSUE: if (!i_i2c_busy) begin
        w_issue     = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (i_i2c_done && !i_i2c_err) begin
          w_rx        = 1'b1;
          w_state_nxt = w_last ? S_DONE : S_ISSUE;
        end else if ((i_i2c_done && i_i2c_err) || w_tmo) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_int_q    <= '1;
      r_pending  <= '0;
      r_overrun  <= '0;
      r_rr       <= '0;
      r_sensor   <= '0;
      r_byte_cnt <= '0;
      r_zidx     <= '0;
      r_bsub     <= '0;
      r_shift    <= '0;
      r_timer    <= '0;
      r_start    <= 1'b0;
      r_addr     <= '0;
      r_zvalid   <= 1'b0;
      r_zsensor  <= '0;
      r_zidx_o   <= '0;
      r_zdata    <= '0;
      r_fdone    <= 1'b0;
      r_ferr     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_int_q   <= i_tof_int;
      // A new edge wins over the arbiter's clear, so a re-trigger is never lost.
      r_pending <= (r_pending & ~w_clr) | w_rise;
      r_overrun <= r_overrun | (w_rise & (r_pending | w_svc));
      r_start   <= w_issue;
      r_zvalid  <= 1'b0;
      r_fdone   <= 1'b0;
      r_ferr    <= 1'b0;
      if (w_arb) begin
        r_sensor   <= w_pick[SW-1:0];
        r_byte_cnt <= '0;
        r_zidx     <= '0;
        r_bsub     <= '0;
        r_busy     <= 1'b1;
      end
      if (w_issue) begin
        r_addr  <= DATA_BASE_ADDR + 16'(r_byte_cnt);
        r_timer <= '0;
      end
      if (r_state == S_WAIT && !w_rx && !w_abort) r_timer <= r_timer + 1'b1;
      if (w_rx) begin
        r_shift    <= w_shift_nxt;
        r_byte_cnt <= r_byte_cnt + 1'b1;
        if (w_zend) begin
          r_zvalid  <= 1'b1;
          r_zdata   <= w_shift_nxt;
          r_zidx_o  <= r_zidx;
          r_zsensor <= r_sensor;
          r_zidx    <= r_zidx + 1'b1;
          r_bsub    <= '0;
        end else begin
          r_bsub <= r_bsub + 1'b1;
        end
        if (w_last) begin
          r_fdone <= 1'b1;
          r_busy  <= 1'b0;
          r_rr    <= w_rr_nxt;
        end
      end
      if (w_abort) begin
        r_ferr <= 1'b1;
        r_busy <= 1'b0;
      end
    end
  end

  assign o_i2c_start   = r_start;
  assign o_i2c_addr    = r_addr;
  assign o_i2c_sensor  = r_sensor;
  assign o_zone_valid  = r_zvalid;
  assign o_zone_sensor = r_zsensor;
  assign o_zone_idx    = r_zidx_o;
  assign o_zone_data   = r_zdata;
  assign o_frame_done  = r_fdone;
  assign o_frame_err   = r_ferr;
  assign o_overrun     = r_overrun;
  assign o_busy        = r_busy;

endmodule

// File: tb/tb_tof_frame_reader.sv
// Scoreboard bench for tof_frame_reader: 2 sensors, 4 zones x 2 bytes, timeout 50 cycles.
module tb_tof_frame_reader;

  logic        clk, reset, i_rd_enable, i_i2c_busy, i_i2c_done, i_i2c_err;
  logic [1:0]  i_tof_int;
  logic [7:0]  i_i2c_rdata;
  logic        o_i2c_start, o_zone_valid, o_frame_done, o_frame_err, o_busy;
  logic [15:0] o_i2c_addr;
  logic        o_i2c_sensor, o_zone_sensor;
  logic [1:0]  o_zone_idx, o_overrun;
  logic [15:0] o_zone_data;

  tof_frame_reader #(
    .N_SENSORS(2), .N_ZONES(4), .BYTES_PER_ZONE(2),
    .DATA_BASE_ADDR(16'h0400), .TIMEOUT_CYC(50)
  ) dut (
    .clk(clk), .reset(reset), .i_rd_enable(i_rd_enable), .i_tof_int(i_tof_int),
    .i_i2c_busy(i_i2c_busy), .i_i2c_done(i_i2c_done), .i_i2c_err(i_i2c_err),
    .i_i2c_rdata(i_i2c_rdata), .o_i2c_start(o_i2c_start), .o_i2c_addr(o_i2c_addr),
    .o_i2c_sensor(o_i2c_sensor), .o_zone_valid(o_zone_valid), .o_zone_sensor(o_zone_sensor),
    .o_zone_idx(o_zone_idx), .o_zone_data(o_zone_data), .o_frame_done(o_frame_done),
    .o_frame_err(o_frame_err), .o_overrun(o_overrun), .o_busy(o_busy)
  );

  typedef struct { int kind; int sensor; int idx; int data; int dly; } ev_t;  // kind 0 zone, 1 done, 2 err
  typedef struct { int sensor; int addr; } ad_t;

  ev_t exp_ev[$];
  ad_t exp_addr[$];
  int  nvec = 0, nerr = 0, cyc = 0, last_start = 0;
  int  err_byte = -1;
  bit  withhold = 0;

  // Sensor register contents and the zone words they must assemble into.
  int btab[2][8] = '{'{'h01, 'h2C, 'h03, 'hE8, 'h7F, 'hFF, 'h00, 'h10},
                     '{'hA5, 'h5A, 'h12, 'h34, 'hDE, 'hAD, 'hBE, 'hEF}};
  int ztab[2][4] = '{'{'h012C, 'h03E8, 'h7FFF, 'h0010},
                     '{'hA55A, 'h1234, 'hDEAD, 'hBEEF}};

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_addrs(input int s, input int n);
    for (int k = 0; k < n; k++) exp_addr.push_back('{s, 'h400 + k});
  endtask

  task automatic push_full(input int s);
    push_addrs(s, 8);
    for (int z = 0; z < 4; z++) exp_ev.push_back('{0, s, z, ztab[s][z], -1});
    exp_ev.push_back('{1, s, 0, 0, -1});
  endtask

  task automatic pulse(input logic [1:0] m);
    @(negedge clk) i_tof_int = i_tof_int | m;
    repeat (3) @(negedge clk);
    i_tof_int = i_tof_int & ~m;
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while ((exp_ev.size() != 0 || exp_addr.size() != 0 || o_busy) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    nvec++;
    if (n >= maxc) begin
      nerr++;
      $display("FAIL drain_timeout: %0d events and %0d reads still outstanding after %0d cycles",
               exp_ev.size(), exp_addr.size(), maxc);
      exp_ev.delete();
      exp_addr.delete();
    end
  endtask

  // Monitor: every DUT output event pops the scoreboard.
  task automatic take(input int kind);
    ev_t e;
    if (exp_ev.size() == 0) begin
      nvec++; nerr++;
      $display("FAIL unexpected_event: kind %0d seen, none expected (t=%0t)", kind, $time);
    end else begin
      e = exp_ev.pop_front();
      chk("event_kind", kind, e.kind);
      if (kind == 0) begin
        chk("zone_sensor", int'(o_zone_sensor), e.sensor);
        chk("zone_idx", int'(o_zone_idx), e.idx);
        chk("zone_data", int'(o_zone_data), e.data);
      end
      if (kind == 2 && e.dly >= 0) chk("timeout_delay", cyc - last_start, e.dly);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (o_zone_valid) take(0);
      if (o_frame_done) take(1);
      if (o_frame_err)  take(2);
    end
  end

  // I2C slave model: checks each read request, answers from btab after 0..2 cycles.
  initial begin
    ad_t a;
    int  k, s;
    i_i2c_done = 0; i_i2c_err = 0; i_i2c_rdata = 0;
    forever begin
      @(negedge clk);
      if (o_i2c_start) begin
        if (exp_addr.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL unexpected_start: addr %0h sensor %0d", o_i2c_addr, o_i2c_sensor);
        end else begin
          a = exp_addr.pop_front();
          chk("i2c_addr", int'(o_i2c_addr), a.addr);
          chk("i2c_sensor", int'(o_i2c_sensor), a.sensor);
        end
        last_start = cyc;
        if (!withhold) begin
          k = int'(o_i2c_addr) - 'h400;
          s = int'(o_i2c_sensor);
          if (k < 0 || k > 7) k = 0;
          repeat (k % 3) @(negedge clk);
          i_i2c_done  = 1;
          i_i2c_err   = (k == err_byte);
          i_i2c_rdata = 8'(btab[s][k]);
          @(negedge clk);
          i_i2c_done = 0;
          i_i2c_err  = 0;
        end
      end
    end
  end

  initial begin
    int n;
    reset = 1; i_rd_enable = 1; i_tof_int = 2'b11; i_i2c_busy = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", o_busy, 0);
    chk("rst_start", o_i2c_start, 0);
    chk("rst_addr", int'(o_i2c_addr), 0);
    chk("rst_zvalid", o_zone_valid, 0);
    chk("rst_flags", {o_frame_done, o_frame_err}, 0);
    chk("rst_overrun", int'(o_overrun), 0);
    reset = 0;
    // Interrupts already high at reset release must not look like edges.
    repeat (20) @(negedge clk);
    chk("int_high_at_release", o_busy, 0);
    i_tof_int = 2'b00;
    repeat (3) @(negedge clk);

    push_full(0); pulse(2'b01); drain(400);
    push_full(1); pulse(2'b10); drain(400);
    // rr pointer is back at 0 after sensor 1, so simultaneous edges serve sensor 0 first, twice over.
    push_full(0); push_full(1); pulse(2'b11); drain(800);
    push_full(0); push_full(1); pulse(2'b11); drain(800);

    // Bus error on byte 3: one zone delivered, frame aborted, next frame restarts at base.
    err_byte = 3;
    push_addrs(0, 4);
    exp_ev.push_back('{0, 0, 0, 'h012C, -1});
    exp_ev.push_back('{2, 0, 0, 0, -1});
    pulse(2'b01); drain(400);
    chk("err_busy", o_busy, 0);
    err_byte = -1;
    push_full(0); pulse(2'b01); drain(400);

    // Withheld completion: frame_err exactly 50 cycles after i2c_start.
    withhold = 1;
    push_addrs(1, 1);
    exp_ev.push_back('{2, 1, 0, 0, 50});
    pulse(2'b10); drain(200);
    withhold = 0;
    chk("tmo_busy", o_busy, 0);

    chk("overrun_before", int'(o_overrun), 0);
    push_full(0); push_full(0);
    pulse(2'b01);
    n = 0;
    while (!o_zone_valid && n < 200) begin @(negedge clk); n++; end
    chk("overrun_midframe_seen", int'(n < 200), 1);
    pulse(2'b01); drain(800);
    chk("overrun_after", int'(o_overrun), 'b01);

    // Edge captured while disabled; serviced only once enabled again.
    i_rd_enable = 0;
    pulse(2'b10);
    repeat (30) @(negedge clk);
    chk("disabled_busy", o_busy, 0);
    push_full(1);
    i_rd_enable = 1;
    drain(400);
    chk("overrun_s1_clear", int'(o_overrun), 'b01);

    // Reset mid-frame: silent abandon, everything zero the next cycle.
    withhold = 1;
    push_addrs(0, 1);
    pulse(2'b01);
    n = 0;
    while (exp_addr.size() != 0 && n < 100) begin @(negedge clk); n++; end
    chk("midreset_started", int'(n < 100), 1);
    chk("midreset_busy_pre", o_busy, 1);
    @(negedge clk) reset = 1;
    @(negedge clk);
    chk("midreset_busy", o_busy, 0);
    chk("midreset_start", o_i2c_start, 0);
    chk("midreset_overrun", int'(o_overrun), 0);
    chk("midreset_flags", {o_zone_valid, o_frame_done, o_frame_err}, 0);
    reset = 0;
    withhold = 0;
    repeat (70) @(negedge clk);
    chk("post_reset_idle", o_busy, 0);
    chk("scoreboard_empty", exp_ev.size() + exp_addr.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
